rr_arb3_ctl: RTL

// - Round-robin arbiter that shares one resource among 3 requesters (i0..i2).
// - Grant is registered and one-hot; the owner keeps the grant until it drops
//   its request (lock/hold handshake).
// - nidle = NOR3 of the requests, for clock-gate and sleep logic.
// - Sits in front of shared pad drivers, shared buses or test-mux resources

---
 rtl/rr_arb3_ctl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rr_arb3_ctl.sv
// rr_arb3_ctl: 3-way round-robin arbiter; the owner keeps its registered grant until it drops its request.
// Define ARB3_TIMEOUT_EN to enable hold-timeout preemption (TOUT/TOUT_W); otherwise tout stays 0.
module rr_arb3_ctl #(
  parameter int TOUT_W = 4,
  parameter int TOUT   = 12
) (
  input  logic clk,
  input  logic nrst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic busy,
  output logic nidle,
  output logic tout
);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [2:0] g_q, g_d;
  logic       busy_q, busy_d;
  logic       tout_q, tout_d;
  logic [2:0] req_s;
  logic [2:0] others_s;
  logic       preempt_s;

  if ((TOUT < 1) || (TOUT >= (1 << TOUT_W))) begin : g_tout_range
    $error("rr_arb3_ctl: TOUT must lie in 1..2^TOUT_W-1");
  end

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] idx);
    inc3 = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order from+1, from+2, then from itself.
  function automatic logic [1:0] rr_next(input logic [1:0] from, input logic [2:0] req);
    logic [1:0] a;
    logic [1:0] b;
    a = inc3(from);
    b = inc3(a);
    if (req[a]) begin
      rr_next = a;
    end else if (req[b]) begin
      rr_next = b;
    end else begin
      rr_next = from;
    end
  endfunction

  assign others_s = req_s & ~onehot3(owner_q);

`ifdef ARB3_TIMEOUT_EN
  localparam logic [TOUT_W-1:0] CNT_LAST = TOUT_W'(TOUT - 1);

  logic [TOUT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        blk_q, blk_d;

  // A preempted owner stays masked until it lowers its request once.
  assign req_s     = {i2, i1, i0} & ~blk_q;
  assign preempt_s = (state_q == ST_OWN) && req_s[owner_q] && (|others_s) && (cnt_q == CNT_LAST);

  // Hold-timeout counter and preemption mask next values.
  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q & {i2, i1, i0};
    if ((state_d == ST_OWN) && ((state_q != ST_OWN) || (owner_d != owner_q))) begin
      cnt_d = {TOUT_W{1'b0}};
    end else if ((state_q == ST_OWN) && (|others_s)) begin
      cnt_d = cnt_q + {{(TOUT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (preempt_s) begin
      blk_d = blk_d | onehot3(owner_q);
    end else begin
      blk_d = blk_d;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= {TOUT_W{1'b0}};
      blk_q <= 3'b000;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end
`else
  assign req_s     = {i2, i1, i0};
  assign preempt_s = 1'b0;
`endif

  // State and grant registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      g_q     <= 3'b000;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state: arbitrate from IDLE, hand over on release or preemption.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          state_d = ST_OWN;
          owner_d = rr_next(last_q, req_s);
          last_d  = owner_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!req_s[owner_q] || preempt_s) begin
          if (|others_s) begin
            owner_d = rr_next(owner_q, others_s);
            last_d  = owner_d;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OWN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state, captured by the output registers.
  always_comb begin
    if (state_d == ST_OWN) begin
      g_d = onehot3(owner_d);
    end else begin
      g_d = 3'b000;
    end
    busy_d = |g_d;
    tout_d = preempt_s;
  end

  assign g0    = g_q[0];
  assign g1    = g_q[1];
  assign g2    = g_q[2];
  assign busy  = busy_q;
  assign tout  = tout_q;
  assign nidle = ~(i0 | i1 | i2);

endmodule
